// File: rtl/quadrature_encoder_emulator_if.sv
// Step-command bus into the quadrature encoder emulator (valid/ready handshake).
interface quadrature_encoder_emulator_if #(
   parameter int STEPS_W  = 16,
   parameter int PERIOD_W = 16
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_dir;
   logic [STEPS_W-1:0]  cmd_steps;
   logic [PERIOD_W-1:0] cmd_period;

   modport master (
      output cmd_valid, cmd_dir, cmd_steps, cmd_period,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
      output cmd_ready
   );
endinterface

// File: rtl/quadrature_encoder_emulator.sv
// Emits N single-edge quadrature transitions per command; edge k lands k*P cycles after accept.
// Backpressure: cmd_ready only in IDLE (including the done cycle), so commands wait while busy.
module quadrature_encoder_emulator #(
   parameter int STEPS_W  = 16,
   parameter int PERIOD_W = 16,
   parameter int POS_W    = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   quadrature_encoder_emulator_if.slave  cmd,
   input  logic                          abort,
   output logic                          A,
   output logic                          B,
   output logic [1:0]                    state,
   output logic [POS_W-1:0]              position,
   output logic                          busy,
   output logic                          done
);

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t                fsm;
   logic                dir_q;
   logic [STEPS_W-1:0]  remaining;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] timer;

   logic [PERIOD_W-1:0] period_eff;
   logic                accept;
   logic [1:0]          next_state;
   logic [POS_W-1:0]    next_pos;

   assign cmd.cmd_ready = (fsm == IDLE) && !reset;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign period_eff    = (cmd.cmd_period == '0) ? PERIOD_W'(1) : cmd.cmd_period;

   // Binary count order of the state code is the forward quadrature order.
   assign next_state = dir_q ? (state + 2'd1) : (state - 2'd1);
   assign next_pos   = dir_q ? (position + POS_W'(1)) : (position - POS_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm       <= IDLE;
         state     <= 2'd0;
         A         <= 1'b0;
         B         <= 1'b0;
         position  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dir_q     <= 1'b0;
         remaining <= '0;
         period_q  <= '0;
         timer     <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (accept) begin
                  dir_q     <= cmd.cmd_dir;
                  period_q  <= period_eff;
                  timer     <= period_eff;
                  remaining <= cmd.cmd_steps;
                  if (cmd.cmd_steps == '0) begin
                     done <= 1'b1;
                  end else begin
                     fsm  <= RUN;
                     busy <= 1'b1;
                  end
               end
            end
            RUN: begin
               // Abort takes priority over a due step, including the final one.
               if (abort) begin
                  fsm  <= IDLE;
                  busy <= 1'b0;
                  done <= 1'b1;
               end else if (timer == PERIOD_W'(1)) begin
                  state     <= next_state;
                  A         <= next_state[1] ^ next_state[0];
                  B         <= next_state[1];
                  position  <= next_pos;
                  remaining <= remaining - STEPS_W'(1);
                  timer     <= period_q;
                  if (remaining == STEPS_W'(1)) begin
                     fsm  <= IDLE;
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end else begin
                  timer <= timer - PERIOD_W'(1);
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Directed bench for quadrature_encoder_emulator: vector table plus multi-cycle sequences.
module tb_quadrature_encoder_emulator;
   localparam int STEPS_W  = 16;
   localparam int PERIOD_W = 16;
   localparam int POS_W    = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             abort = 1'b0;
   logic             A, B;
   logic [1:0]       state;
   logic [POS_W-1:0] position;
   logic             busy, done;

   quadrature_encoder_emulator_if #(.STEPS_W(STEPS_W), .PERIOD_W(PERIOD_W)) cmd_if ();

   quadrature_encoder_emulator #(.STEPS_W(STEPS_W), .PERIOD_W(PERIOD_W), .POS_W(POS_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd      (cmd_if),
      .abort    (abort),
      .A        (A),
      .B        (B),
      .state    (state),
      .position (position),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent quadrature decoder watching A/B, mod-32 count.
   int         dec_cnt = 0;
   logic [1:0] dec_prev = 2'd0;
   logic [1:0] dec_cur, dec_d;

   function automatic logic [1:0] ab_idx(input logic a, input logic b);
      case ({a, b})
         2'b00:   return 2'd0;
         2'b10:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         dec_cnt  = 0;
         dec_prev = 2'd0;
      end else begin
         dec_cur = ab_idx(A, B);
         dec_d   = dec_cur - dec_prev;
         if (dec_d == 2'd1) dec_cnt = (dec_cnt + 1) % 32;
         else if (dec_d == 2'd3) dec_cnt = (dec_cnt + 31) % 32;
         dec_prev = dec_cur;
      end
   end

   task automatic drive_cmd(input logic dir, input int steps, input int period);
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_dir    = dir;
      cmd_if.cmd_steps  = STEPS_W'(steps);
      cmd_if.cmd_period = PERIOD_W'(period);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      abort = 1'b0;
      tick();
      tick();
      chk({tag, "_rst_state"}, state, 0);
      chk({tag, "_rst_ab"}, {A, B}, 0);
      chk({tag, "_rst_pos"}, position, 0);
      chk({tag, "_rst_busy_done"}, {busy, done}, 0);
      chk({tag, "_rst_ready"}, cmd_if.cmd_ready, 0);
      reset = 1'b0;
   endtask

   typedef struct {
      logic dir;
      int   steps;
      int   period;
      int   abort_at;
      int   exp_done_k;
      int   exp_edges;
      int   exp_pos;
      int   exp_state;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v, input string tag);
      int         k;
      int         edges;
      logic [1:0] prev_ab;
      logic [1:0] st_end;
      logic [POS_W-1:0] pos_end;
      prev_ab = {A, B};
      drive_cmd(v.dir, v.steps, v.period);
      tick();
      cmd_if.cmd_valid = 1'b0;
      chk({tag, "_busy_after_accept"}, busy, (v.steps != 0));
      k = 0;
      edges = 0;
      while (!done && k < 400) begin
         if (k + 1 == v.abort_at) abort = 1'b1;
         tick();
         abort = 1'b0;
         k++;
         if ({A, B} != prev_ab) edges++;
         prev_ab = {A, B};
      end
      chk({tag, "_done_cycle"}, k, v.exp_done_k);
      chk({tag, "_edges"}, edges, v.exp_edges);
      chk({tag, "_pos"}, position, v.exp_pos);
      chk({tag, "_state"}, state, v.exp_state);
      chk({tag, "_ab_decode"}, {A, B}, {state[1] ^ state[0], state[1]});
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_ready_at_done"}, cmd_if.cmd_ready, 1);
      st_end  = state;
      pos_end = position;
      repeat (3) tick();
      chk({tag, "_quiet_state"}, state, st_end);
      chk({tag, "_quiet_pos"}, position, pos_end);
      chk({tag, "_quiet_done"}, done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int dcount;
      logic [1:0] exp_s [1:7];
      logic [1:0] exp_d [1:7];

      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_dir    = 1'b0;
      cmd_if.cmd_steps  = '0;
      cmd_if.cmd_period = '0;

      // Forward 4 @ period 3: a step every third edge.
      do_reset("fwd4");
      drive_cmd(1'b1, 4, 3);
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk($sformatf("fwd4_state_e%0d", c), state, (c / 3) % 4);
         chk($sformatf("fwd4_pos_e%0d", c), position, c / 3);
         chk($sformatf("fwd4_done_e%0d", c), done, (c == 12));
         chk($sformatf("fwd4_busy_e%0d", c), busy, (c != 12));
      end
      chk("fwd4_ready_at_done", cmd_if.cmd_ready, 1);

      // Reverse 2 @ period 1 from reset, wrapping below zero.
      do_reset("rev2");
      drive_cmd(1'b0, 2, 1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      tick();
      chk("rev2_ab_e1", {A, B}, 2'b01);
      chk("rev2_pos_e1", position, 31);
      chk("rev2_done_e1", done, 0);
      tick();
      chk("rev2_ab_e2", {A, B}, 2'b11);
      chk("rev2_pos_e2", position, 30);
      chk("rev2_done_e2", done, 1);

      // Back-to-back: second command held while busy, taken in the done cycle.
      do_reset("b2b");
      exp_s = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
      exp_d = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      drive_cmd(1'b1, 2, 1);
      tick();
      drive_cmd(1'b0, 2, 2);
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 3) cmd_if.cmd_valid = 1'b0;
         chk($sformatf("b2b_state_e%0d", e), state, exp_s[e]);
         chk($sformatf("b2b_done_e%0d", e), done, exp_d[e]);
         chk($sformatf("b2b_busy_e%0d", e), busy, (e != 2 && e != 7));
         if (e == 1) chk("b2b_ready_e1", cmd_if.cmd_ready, 0);
         if (e == 2) chk("b2b_ready_e2", cmd_if.cmd_ready, 1);
      end
      chk("b2b_pos_end", position, 0);

      // Loopback into the decoder model, then reset mid-command.
      do_reset("loop");
      drive_cmd(1'b1, 40, 4);
      tick();
      cmd_if.cmd_valid = 1'b0;
      k = 0;
      while (!done && k < 400) begin
         tick();
         k++;
      end
      chk("loop_done_cycle", k, 160);
      chk("loop_pos", position, 8);
      tick();
      chk("loop_decoder_cnt", dec_cnt, 8);
      drive_cmd(1'b1, 40, 4);
      tick();
      cmd_if.cmd_valid = 1'b0;
      repeat (21) tick();
      chk("loop_midcmd_busy", busy, 1);
      reset = 1'b1;
      tick();
      chk("loop_mrst_ab", {A, B}, 0);
      chk("loop_mrst_pos", position, 0);
      chk("loop_mrst_state", state, 0);
      chk("loop_mrst_busy_done", {busy, done}, 0);
      chk("loop_mrst_ready", cmd_if.cmd_ready, 0);
      reset = 1'b0;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dcount++;
      end
      chk("loop_mrst_no_done", dcount, 0);
      chk("loop_mrst_idle", {busy, position}, 0);

      // Chained vector table starting from reset.
      vecs[0] = '{1'b1,  4, 3, 0, 12, 4,  4, 0};
      vecs[1] = '{1'b0,  2, 1, 0,  2, 2,  2, 2};
      vecs[2] = '{1'b1,  0, 5, 0,  0, 0,  2, 2};
      vecs[3] = '{1'b1, 10, 2, 7,  7, 3,  5, 1};
      vecs[4] = '{1'b0,  5, 0, 0,  5, 5,  0, 0};
      vecs[5] = '{1'b1,  3, 1, 3,  3, 2,  2, 2};
      vecs[6] = '{1'b0,  3, 2, 0,  6, 3, 31, 3};
      do_reset("tbl");
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Abort while idle has no effect.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_done", done, 0);
      chk("idle_abort_state", state, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/quadrature_encoder_emulator.md
Name: quadrature_encoder_emulator

Overview:
- Generates quadrature A/B waveforms from step commands; the transmit-side counterpart of the quadrature decoder.
- Drives decoder inputs in loopback benches and emulates a motor encoder toward external equipment.
- Each accepted command produces N single-edge quadrature transitions in one direction at a programmable spacing.
- Tracks its own position with the same wrap-around count arithmetic the decoder uses.

Parameters:
STEPS_W, 16, width of the per-command step count
PERIOD_W, 16, width of the edge-spacing field in clk cycles
POS_W, 5, width of the position counter; wraps modulo 2^POS_W

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_dir  input  1  1 = forward (count up), 0 = reverse (count down)
cmd_steps  input  STEPS_W  number of quadrature edges to emit
cmd_period  input  PERIOD_W  clk cycles between edges; 0 is treated as 1
abort  input  1  stop the active command at the next clk edge
A  output  1  quadrature channel A (registered)
B  output  1  quadrature channel B (registered)
state  output  2  current quadrature state {S0..S3}
position  output  POS_W  signed-wrap position count
busy  output  1  command in progress
done  output  1  one-cycle pulse when a command completes or is aborted

Behaviour:
- State encoding and outputs:
  - S0=00 (A=0,B=0), S1=01 (A=1,B=0), S2=10 (A=1,B=1), S3=11 (A=0,B=1).
  - A and B are decoded from the state register, so exactly one of them changes per transition.
- Step direction:
  - Forward: S0→S1→S2→S3→S0, position +1 per edge.
  - Reverse: S0→S3→S2→S1→S0, position −1 per edge.
  - Position wraps modulo 2^POS_W (31+1=0; 0−1=31 for POS_W=5).
- Reset (synchronous, active-high):
  - state=S0, A=0, B=0, position=0, busy=0, done=0, cmd_ready=0 while reset is high.
  - Reset mid-command discards the command with no done pulse.
- Control FSM states:
  - IDLE: cmd_ready=1 (when reset is low).
  - RUN: cmd_ready=0, busy=1.
- Accept: cmd_valid & cmd_ready at clk edge T.
  - Latch dir, steps, and P = max(cmd_period,1).
  - If steps=0: stay IDLE, pulse done at T (visible cycle after T), no A/B change.
  - Otherwise go to RUN with timer=P and remaining=steps.
- RUN, each cycle:
  - timer decrements.
  - When timer==1 at an edge: advance state one step, update position, remaining−1, reload timer=P.
  - Resulting timing: first A/B transition at edge T+P; subsequent transitions every P cycles; edge k at T+k·P.
- Completion:
  - The edge that emits the final step also clears busy and sets done for one cycle → IDLE.
  - cmd_ready is high in the same cycle done is high, so back-to-back commands are legal with no gap cycle.
- Abort:
  - abort high in RUN at edge E: no step at E, even if timer==1; busy→0, done=1 for one cycle, → IDLE.
  - state and position are retained.
  - Abort in IDLE is ignored.
  - Abort and final step on the same edge: abort wins, so the final step is not emitted.
- cmd_valid while busy: ignored; the requester must hold it until cmd_ready.
- No output glitches: A, B, position, busy and done are all registers.

Test Plan:
- Reset, then cmd forward steps=4 period=3 at edge 0 → state S1,S2,S3,S0 at edges 3,6,9,12; position 1,2,3,4; done pulse and busy low after edge 12; cmd_ready high that cycle.
- From reset, reverse steps=2 period=1 → (A,B)=(0,1) then (1,1) on consecutive edges; position 31 then 30; done after edge 2.
- steps=0 period=5 → no A/B change; done pulses one cycle after accept; position stays 0; busy never asserted.
- Forward steps=10 period=2, abort asserted at edge 7 → exactly 3 edges emitted (edges 2,4,6); position=3, state=S3; done at edge 7; no further transitions.
- Back-to-back: forward 2 (period 1) then reverse 2 (period 2) accepted in the done cycle → state sequence S1,S2,S1,S0, position returns to 0, no idle gap at the handoff.
- Loopback into the decoder (shared clk, reset low): forward 40 steps period 4 → position wraps to 8 (40 mod 32) and the decoder count matches; reset asserted mid-command → A=B=0, position=0, no done pulse.
